// File: rtl/cla_pkg.sv
// Shared defaults and the per-stage pipeline record for the pipelined CLA adder.
package cla_pkg;

    localparam int CLA_WIDTH  = 64;
    localparam int CLA_STAGES = 4;

    // Fields are sized for the default width; a narrower adder leaves the upper bits at zero.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [CLA_WIDTH-1:0] sum;
        logic [CLA_WIDTH-1:0] a;
        logic [CLA_WIDTH-1:0] b;
    } cla_stage_t;

    function automatic logic cla_is_zero(input logic [CLA_WIDTH-1:0] v);
        return (v == {CLA_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational N-bit carry-lookahead slice: every carry is a flat sum of
// generate/propagate products rather than a ripple chain.
module cla_slice #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_msb_cin
);

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N-1:0] w_c;
    logic         w_grp_g;
    logic         w_grp_p;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Lookahead carries per bit; the top term yields the group generate/propagate.
    always_comb begin
        logic v_acc;
        logic v_pp;
        w_c     = {N{1'b0}};
        w_grp_g = 1'b0;
        w_grp_p = 1'b0;
        v_acc   = 1'b0;
        v_pp    = 1'b0;
        w_c[0]  = i_cin;
        for (int i = 0; i < N; i++) begin
            v_acc = w_g[i];
            v_pp  = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                v_acc = v_acc | (v_pp & w_g[j]);
                v_pp  = v_pp & w_p[j];
            end
            if (i < N - 1) begin
                w_c[i+1] = v_acc | (v_pp & i_cin);
            end else begin
                w_grp_g = v_acc;
                w_grp_p = v_pp;
            end
        end
    end

    assign o_sum     = w_p ^ w_c;
    assign o_cout    = w_grp_g | (w_grp_p & i_cin);
    assign o_msb_cin = w_c[N-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined add/subtract: one CLA slice per stage, operands and partial sums
// skewed through the stage records so each transaction stays aligned.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = CLA_WIDTH,
    parameter int STAGES = CLA_STAGES
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry_in,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_carry_out,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int SW = WIDTH / STAGES;

    cla_stage_t       r_stage [STAGES];
    cla_stage_t       w_next  [STAGES];
    logic [SW-1:0]    w_sa    [STAGES];
    logic [SW-1:0]    w_sb    [STAGES];
    logic [SW-1:0]    w_ss    [STAGES];
    logic             w_sc    [STAGES];
    logic             w_sco   [STAGES];
    logic             w_smsb  [STAGES];
    logic [WIDTH-1:0] w_b_eff;
    logic             w_advance;
    logic             w_overflow;
    logic             w_zero;
    logic             r_overflow;
    logic             r_zero;

    // The whole pipe moves as one: it stalls only when a held result is refused.
    assign w_advance = !r_stage[STAGES-1].valid || i_ready;
    assign o_ready   = w_advance;
    assign w_b_eff   = i_b ^ {WIDTH{i_sub}};

    // Slice operands: stage 0 straight from the ports, later stages from the skew registers.
    always_comb begin
        w_sa[0] = i_a[SW-1:0];
        w_sb[0] = w_b_eff[SW-1:0];
        w_sc[0] = i_carry_in ^ i_sub;
        for (int k = 1; k < STAGES; k++) begin
            w_sa[k] = r_stage[k-1].a[k*SW +: SW];
            w_sb[k] = r_stage[k-1].b[k*SW +: SW];
            w_sc[k] = r_stage[k-1].carry;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slice
        cla_slice #(
            .N(SW)
        ) u_slice (
            .i_a      (w_sa[g]),
            .i_b      (w_sb[g]),
            .i_cin    (w_sc[g]),
            .o_sum    (w_ss[g]),
            .o_cout   (w_sco[g]),
            .o_msb_cin(w_smsb[g])
        );
    end

    // Next stage records: each stage inserts its slice of the sum into the carried-forward record.
    always_comb begin
        w_next[0].valid         = i_valid;
        w_next[0].carry         = w_sco[0];
        w_next[0].sum           = {CLA_WIDTH{1'b0}};
        w_next[0].sum[SW-1:0]   = w_ss[0];
        w_next[0].a             = CLA_WIDTH'(i_a);
        w_next[0].b             = CLA_WIDTH'(w_b_eff);
        for (int k = 1; k < STAGES; k++) begin
            w_next[k]                  = r_stage[k-1];
            w_next[k].carry            = w_sco[k];
            w_next[k].sum[k*SW +: SW]  = w_ss[k];
        end
        w_overflow = w_smsb[STAGES-1] ^ w_sco[STAGES-1];
        w_zero     = cla_is_zero(w_next[STAGES-1].sum);
    end

    // Stage registers and output flags; everything holds while the pipe is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= {$bits(cla_stage_t){1'b0}};
            end
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= w_next[k];
            end
            r_overflow <= w_overflow;
            r_zero     <= w_zero;
        end
    end

    assign o_valid     = r_stage[STAGES-1].valid;
    assign o_s         = r_stage[STAGES-1].sum[WIDTH-1:0];
    assign o_carry_out = r_stage[STAGES-1].carry;
    assign o_overflow  = r_overflow;
    assign o_zero      = r_zero;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed and streaming checks for the 64-bit, 4-stage pipelined CLA adder.
module tb_cla_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_a;
    logic [63:0] i_b;
    logic        i_carry_in;
    logic        i_sub;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_s;
    logic        o_carry_out;
    logic        o_overflow;
    logic        o_zero;

    int checks = 0;
    int errors = 0;

    cla_adder_pipe #(
        .WIDTH (64),
        .STAGES(4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_carry_in (i_carry_in),
        .i_sub      (i_sub),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_s        (o_s),
        .o_carry_out(o_carry_out),
        .o_overflow (o_overflow),
        .o_zero     (o_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t        vecs [11];
    logic [63:0] tx_a [16];
    logic [63:0] tx_b [16];
    logic        tx_c [16];
    logic        tx_u [16];
    logic [65:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: {overflow, carry_out, sum} from plain wide arithmetic.
    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] bb;
        logic [64:0] r;
        logic        ov;
        bb = b ^ {64{sub}};
        r  = {1'b0, a} + {1'b0, bb} + {64'd0, cin ^ sub};
        ov = (a[63] == bb[63]) && (r[63] != a[63]);
        return {ov, r};
    endfunction

    task automatic run_stream(input int n, input int stall_at, input int stall_len, input bit timed);
        int          sent;
        int          got;
        int          cyc;
        bit          prev_stall;
        logic [63:0] prev_s;
        logic [65:0] e;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_s = 64'd0;
        exp_q.delete();
        while (got < n && cyc < 200) begin
            @(negedge clk);
            i_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (sent < n) begin
                i_valid = 1'b1; i_a = tx_a[sent]; i_b = tx_b[sent];
                i_carry_in = tx_c[sent]; i_sub = tx_u[sent];
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("hold_s", o_s, prev_s);
                chk("hold_valid", {63'd0, o_valid}, 64'd1);
            end
            if (o_valid && !i_ready) chk("stall_ready", {63'd0, o_ready}, 64'd0);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stream_spurious actual=valid required=no_output cycle=%0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream%0d_s", got), o_s, e[63:0]);
                    chk($sformatf("stream%0d_co", got), {63'd0, o_carry_out}, {63'd0, e[64]});
                    chk($sformatf("stream%0d_ov", got), {63'd0, o_overflow}, {63'd0, e[65]});
                    if (timed) chk($sformatf("stream%0d_cycle", got), 64'(cyc), 64'(got + 4));
                end
                got++;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_a, i_b, i_carry_in, i_sub));
                sent++;
            end
            prev_stall = o_valid && !i_ready;
            prev_s     = o_s;
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("stream_count", 64'(got), 64'(n));
    endtask

    initial begin
        int lat;
        int stale;

        vecs[0]  = '{64'h123456789ABCDEF0, 64'hFEDCBA9876543210, 1'b0, 1'b0, 64'h1111111111111100, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{64'h8000000000000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h8000000000000000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{64'h7, 64'h5, 1'b1, 1'b1, 64'h1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{64'h00000000FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0000000100000000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{64'h000000000000FFFF, 64'h1, 1'b1, 1'b0, 64'h0000000000010001, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            tx_a[i] = {$urandom, $urandom};
            tx_b[i] = {$urandom, $urandom};
            tx_c[i] = 1'($urandom_range(1, 0));
            tx_u[i] = 1'($urandom_range(1, 0));
        end

        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_a = 64'd0; i_b = 64'd0; i_carry_in = 1'b0; i_sub = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_s", o_s, 64'd0);
        chk("rst_flags", {61'd0, o_carry_out, o_overflow, o_zero}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Isolated directed vectors, each with its latency measured.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            i_valid = 1'b1; i_a = vecs[i].a; i_b = vecs[i].b;
            i_carry_in = vecs[i].cin; i_sub = vecs[i].sub;
            lat = 0;
            do begin
                @(negedge clk);
                i_valid = 1'b0;
                lat++;
                #1;
            end while (!o_valid && lat < 20);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_s", i), o_s, vecs[i].s);
            chk($sformatf("vec%0d_co", i), {63'd0, o_carry_out}, {63'd0, vecs[i].co});
            chk($sformatf("vec%0d_ov", i), {63'd0, o_overflow}, {63'd0, vecs[i].ov});
            chk($sformatf("vec%0d_zero", i), {63'd0, o_zero}, {63'd0, vecs[i].z});
        end
        repeat (2) @(negedge clk);

        // Back-to-back without stalls, then with a 3-cycle stall on a full pipe.
        run_stream(8, 1000, 0, 1'b1);
        repeat (2) @(negedge clk);
        run_stream(8, 5, 3, 1'b0);
        repeat (2) @(negedge clk);

        // Reset with results in flight.
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_valid = 1'b1; i_a = tx_a[i]; i_b = tx_b[i];
            i_carry_in = tx_c[i]; i_sub = tx_u[i];
        end
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        chk("pre_rst_valid", {63'd0, o_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, o_valid}, 64'd0);
        chk("async_rst_s", o_s, 64'd0);
        chk("async_rst_co", {63'd0, o_carry_out}, 64'd0);
        chk("async_rst_ready", {63'd0, o_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        i_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (o_valid) stale++;
        end
        chk("no_stale_after_rst", 64'(stale), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_adder_pipe.md
CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; each stage SHALL add WIDTH/STAGES bits.
REQ-003 i_clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 i_valid  in  1  upstream operand valid.
REQ-006 o_ready  out  1  adder accepts operands this cycle.
REQ-007 i_a, i_b  in  WIDTH  operands.
REQ-008 i_carry_in  in  1  carry-in for add; borrow-in for subtract.
REQ-009 i_sub  in  1  0 = add, 1 = subtract.
REQ-010 o_valid  out  1  result valid.
REQ-011 i_ready  in  1  downstream accepts the result.
REQ-012 o_s  out  WIDTH  sum or difference.
REQ-013 o_carry_out  out  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-014 o_overflow  out  1  signed (two's-complement) overflow.
REQ-015 o_zero  out  1  o_s equals zero.

Function
REQ-016 Result SHALL be {o_carry_out,o_s} = i_a + (i_b XOR {WIDTH{i_sub}}) + (i_carry_in XOR i_sub).
- Subtract with i_carry_in=0 gives A-B; with i_carry_in=1 gives A-B-1.
REQ-017 Stage k (0..STAGES-1) SHALL compute operand bits [k*W/S +: W/S] with a combinational carry-lookahead slice, using the carry registered by stage k-1.
- Stage 0 SHALL use the effective carry-in.
REQ-018 Operand slices not yet consumed and result slices already produced SHALL be carried forward in skew registers, so that each in-flight transaction stays aligned.
REQ-019 Latency SHALL be exactly STAGES cycles from an accepted handshake (i_valid && o_ready) to o_valid, absent stalls.
REQ-020 The pipeline SHALL accept one transaction per cycle when not stalled.
REQ-021 Stall rule: advance = !o_valid || i_ready, and o_ready SHALL equal advance.
- When advance=0, all stage registers, valid bits and outputs SHALL hold.
REQ-022 Each stage SHALL carry a valid bit; bubbles SHALL propagate as invalid and SHALL never assert o_valid.
REQ-023 o_overflow SHALL equal the carry into the MSB XOR the carry out of the MSB, computed in the final stage.
REQ-024 o_zero SHALL be computed on the full registered o_s.
REQ-025 All outputs SHALL be registered; o_s, flags and o_valid SHALL change together.
REQ-026 Once o_valid is asserted, o_s and the flags SHALL stay stable until i_ready is sampled high.
REQ-027 Simultaneous output drain and input accept in the same cycle SHALL lose no data and duplicate no data.
REQ-028 Wrap-around: all-ones + 1 SHALL give o_s=0, o_carry_out=1, o_zero=1.

Reset
REQ-029 While i_rst_n=0, all valid bits SHALL clear asynchronously.
- o_valid=0, o_s=0, o_carry_out=0, o_overflow=0, o_zero=0.
REQ-030 o_ready SHALL be 1 during and after reset.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions.
- After deassertion, no stale result SHALL appear.

Structure
REQ-032 Package cla_pkg SHALL hold the WIDTH/STAGES defaults and a stage-register struct typedef (valid, carry, partial sum, remaining operands).
REQ-033 Sub-module cla_slice SHALL implement the combinational WIDTH/STAGES-bit CLA: generate/propagate, group carries, sum, carry-out, MSB carry-in.
- It SHALL be instantiated STAGES times via generate.

Verification (WIDTH=64, STAGES=4)
REQ-034 Add 64'h123456789ABCDEF0 + 64'hFEDCBA9876543210, cin=0, i_ready=1 -> after exactly 4 cycles: o_s=64'h1111111111111100, o_carry_out=1, o_overflow=0.
REQ-035 Sub 64'h5 - 64'h7, cin=0 -> o_s=64'hFFFFFFFFFFFFFFFE, o_carry_out=0, o_overflow=0; 64'h8000000000000000 - 1 -> o_overflow=1.
REQ-036 Wrap-around: 64'hFFFFFFFFFFFFFFFF + 0, cin=1 -> o_s=0, o_carry_out=1, o_zero=1.
REQ-037 Back-to-back: 8 consecutive transactions, i_ready=1 -> 8 results on consecutive cycles starting at cycle 4, in order, values correct.
REQ-038 Backpressure: hold i_ready=0 for 3 cycles with a full pipe -> o_ready=0, o_s held stable, no loss; on release, results resume in order.
REQ-039 Pulse i_rst_n low with 3 transactions in flight -> o_valid=0 immediately; no output for 4 cycles after release without new input.
